// File: rtl/cajero_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cajero_pkg
// Description : Shared state encodings and constants for the ATM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cajero_pkg;

    // One-hot controller states
    localparam logic [5:0] c_ST_IDLE           = 6'b000001;
    localparam logic [5:0] c_ST_RECIBIENDO_PIN = 6'b000010;
    localparam logic [5:0] c_ST_COMPARAR_PIN   = 6'b000100;
    localparam logic [5:0] c_ST_ESPERA_MONTO   = 6'b001000;
    localparam logic [5:0] c_ST_TRANSACCION    = 6'b010000;
    localparam logic [5:0] c_ST_BLOQUEO        = 6'b100000;

    localparam logic [3:0] c_CERO   = 4'h0;
    localparam logic [3:0] c_UNO    = 4'h1;
    localparam logic [3:0] c_DOS    = 4'h2;
    localparam logic [3:0] c_TRES   = 4'h3;
    localparam logic [3:0] c_CUATRO = 4'h4;
    localparam logic [3:0] c_CINCO  = 4'h5;
    localparam logic [3:0] c_SEIS   = 4'h6;
    localparam logic [3:0] c_SIETE  = 4'h7;
    localparam logic [3:0] c_OCHO   = 4'h8;
    localparam logic [3:0] c_NUEVE  = 4'h9;
    localparam logic [3:0] c_VACIO  = 4'hF;

    localparam logic c_DEPOSITO = 1'b0;
    localparam logic c_RETIRO   = 1'b1;

    function automatic logic es_digito_valido(input logic [3:0] digito);
        return digito <= c_NUEVE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cajero_pin_colector.sv
`default_nettype none
// ============================================================================
// Module      : cajero_pin_colector
// Description : Accepts BCD keypad digits into a PIN shift register and flags
//               the edge on which the final digit is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module cajero_pin_colector
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_habilitar,
    input  logic                    i_digito_stb,
    input  logic [3:0]              i_digito,
    output logic [4*PIN_DIGITS-1:0] o_pin_recibido,
    output logic                    o_pin_completo
);

    localparam int                 c_CNT_W  = $clog2(PIN_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_ULTIMO = c_CNT_W'(PIN_DIGITS - 1);

    logic [c_CNT_W-1:0]      r_cuenta;
    logic [4*PIN_DIGITS-1:0] r_pin;
    logic [4*PIN_DIGITS-1:0] w_pin_desplazado;
    logic                    w_aceptar;

    assign w_aceptar = i_habilitar && i_digito_stb && es_digito_valido(i_digito);

    // New digits enter at the LS nibble so the first digit ends up MS
    generate
        if (PIN_DIGITS == 1) begin : g_un_digito
            assign w_pin_desplazado = i_digito;
        end else begin : g_varios_digitos
            assign w_pin_desplazado = {r_pin[4*PIN_DIGITS-5:0], i_digito};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cuenta <= '0;
            r_pin    <= '0;
        end else if (w_aceptar) begin
            r_pin    <= w_pin_desplazado;
            r_cuenta <= r_cuenta + c_CNT_W'(1);
        end
    end

    assign o_pin_recibido = r_pin;
    assign o_pin_completo = w_aceptar && (r_cuenta == c_ULTIMO);

endmodule
`default_nettype wire

// File: rtl/cajero_param.sv
`default_nettype none
// ============================================================================
// Module      : cajero_param
// Description : ATM transaction controller: PIN entry with attempt lockout,
//               followed by a single deposit or withdrawal against the balance.
// Revision    : 1.0 - initial release
// ============================================================================
module cajero_param
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int BALANCE_W    = 32,
    parameter int MONTO_W      = 32,
    parameter int MAX_INTENTOS = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    tipo_trans,
    input  logic                    digito_stb,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin,
    input  logic                    monto_stb,
    input  logic [MONTO_W-1:0]      monto,
    input  logic [BALANCE_W-1:0]    balance,
    output logic [BALANCE_W-1:0]    balance_actualizado,
    output logic                    balance_stb,
    output logic                    entregar_dinero,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic                    fondos_insuficientes
);

    localparam int                 c_INT_W     = $clog2(MAX_INTENTOS + 1);
    localparam logic [c_INT_W-1:0] c_MAX_INT   = c_INT_W'(MAX_INTENTOS);
    localparam logic [c_INT_W-1:0] c_AVISO_INT = c_INT_W'(MAX_INTENTOS - 1);

    logic [5:0]              r_estado;
    logic [c_INT_W-1:0]      r_intentos;
    logic [MONTO_W-1:0]      r_monto;
    logic                    r_tipo;

    logic                    w_rst;
    logic                    w_clear_pin;
    logic                    w_habilitar_pin;
    logic                    w_pin_completo;
    logic [4*PIN_DIGITS-1:0] w_pin_recibido;
    logic                    w_pin_ok;
    logic [c_INT_W-1:0]      w_intentos_inc;
    logic [BALANCE_W-1:0]    w_monto_ext;
    logic [BALANCE_W:0]      w_suma;
    logic [BALANCE_W-1:0]    w_resta;
    logic                    w_fondos_ok;

    assign w_rst           = !reset;
    // The collector stays cleared outside PIN entry so every entry starts fresh
    assign w_clear_pin     = (r_estado != c_ST_RECIBIENDO_PIN) || !tarjeta_recibida;
    assign w_habilitar_pin = (r_estado == c_ST_RECIBIENDO_PIN) && tarjeta_recibida;

    cajero_pin_colector #(
        .PIN_DIGITS (PIN_DIGITS)
    ) u_pin_colector (
        .clk            (clock),
        .rst            (w_rst),
        .i_clear        (w_clear_pin),
        .i_habilitar    (w_habilitar_pin),
        .i_digito_stb   (digito_stb),
        .i_digito       (digito),
        .o_pin_recibido (w_pin_recibido),
        .o_pin_completo (w_pin_completo)
    );

    assign w_pin_ok       = (w_pin_recibido == pin);
    assign w_intentos_inc = r_intentos + c_INT_W'(1);
    assign w_monto_ext    = BALANCE_W'(r_monto);
    assign w_suma         = {1'b0, balance} + {1'b0, w_monto_ext};
    assign w_resta        = balance - w_monto_ext;
    assign w_fondos_ok    = (w_monto_ext <= balance);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado             <= c_ST_IDLE;
            r_intentos           <= '0;
            r_monto              <= '0;
            r_tipo               <= c_DEPOSITO;
            balance_actualizado  <= '0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
        end else begin
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            fondos_insuficientes <= 1'b0;

            case (r_estado)
                c_ST_IDLE: begin
                    if (tarjeta_recibida) begin
                        r_estado <= c_ST_RECIBIENDO_PIN;
                    end
                end

                c_ST_RECIBIENDO_PIN: begin
                    if (!tarjeta_recibida) begin
                        r_estado <= c_ST_IDLE;
                    end else if (w_pin_completo) begin
                        r_estado <= c_ST_COMPARAR_PIN;
                    end
                end

                c_ST_COMPARAR_PIN: begin
                    if (w_pin_ok) begin
                        r_intentos  <= '0;
                        advertencia <= 1'b0;
                        r_estado    <= tarjeta_recibida ? c_ST_ESPERA_MONTO : c_ST_IDLE;
                    end else begin
                        r_intentos     <= w_intentos_inc;
                        pin_incorrecto <= 1'b1;
                        if (w_intentos_inc == c_MAX_INT) begin
                            r_estado    <= c_ST_BLOQUEO;
                            bloqueo     <= 1'b1;
                            advertencia <= 1'b0;
                        end else begin
                            advertencia <= (w_intentos_inc == c_AVISO_INT);
                            r_estado    <= tarjeta_recibida ? c_ST_RECIBIENDO_PIN : c_ST_IDLE;
                        end
                    end
                end

                c_ST_ESPERA_MONTO: begin
                    if (!tarjeta_recibida) begin
                        r_estado <= c_ST_IDLE;
                    end else if (monto_stb) begin
                        r_monto  <= monto;
                        r_tipo   <= tipo_trans;
                        r_estado <= c_ST_TRANSACCION;
                    end
                end

                c_ST_TRANSACCION: begin
                    if (r_tipo == c_DEPOSITO) begin
                        balance_actualizado <= w_suma[BALANCE_W] ? {BALANCE_W{1'b1}}
                                                                 : w_suma[BALANCE_W-1:0];
                        balance_stb         <= 1'b1;
                    end else if (w_fondos_ok) begin
                        balance_actualizado <= w_resta;
                        balance_stb         <= 1'b1;
                        entregar_dinero     <= 1'b1;
                    end else begin
                        fondos_insuficientes <= 1'b1;
                    end
                    r_estado <= c_ST_IDLE;
                end

                c_ST_BLOQUEO: begin
                    bloqueo     <= 1'b1;
                    advertencia <= 1'b0;
                end

                default: begin
                    r_estado <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
